arbiter_puf_array: RTL and testbench
====================================

// Module: arbiter_puf_array
// PURPOSE
// - Parametrised multi-chain arbiter PUF with an on-chip evaluation controller.
// - Holds N_CHAINS switch-box delay chains of N_STAGES stages each. Every chain ends in an async-cleared arbiter flop.
// - An FSM accepts a challenge over valid/ready, then runs arm/launch/settle/sample, optionally repeated and majority-voted.
// - Returns an N_CHAINS-bit response plus its XOR over valid/ready. Sits between the key/auth logic and the PUF fabric.
// PARAMETERS
// - N_STAGES    64   switch-box stages per chain (>=2)
// - N_CHAINS    4    parallel chains; chain c sees challenge rotated left by c bits
// - SETTLE_CYC  8    clk cycles allowed for race propagation, and for line relaxation (>=1)
// - VOTES       5    evaluations per challenge when PUF_VOTE_EN is defined (odd, >=1)
// - DLY_UP      0.1  (real, ns) sim-only delay of each stage's upper mux
// - DLY_DN      0.2  (real, ns) sim-only delay of each stage's lower mux
// PORTS
// - clk         in   1          system clock
// - reset       in   1          asynchronous, active-high
// - chal_valid  in   1          challenge offered
// - chal_ready  out  1          controller idle; accepts challenge
// - chal        in   N_STAGES   stage selects; bit i drives stage i
// - resp_valid  out  1          response available
// - resp_ready  in   1          consumer accepts response
// - resp        out  N_CHAINS   per-chain (voted) arbiter result
// - resp_xor    out  1          ^resp
// - busy        out  1          state != IDLE
// BEHAVIOUR
// - Reset: reset is asynchronous, active-high; clock is clk.
//   - State goes to IDLE; launch=0; arbiters cleared; vote counters=0.
//   - Outputs: resp=0, resp_xor=0, resp_valid=0, chal_ready=1, busy=0.
//   - Reset asserted in any state aborts the evaluation. No partial response is ever presented.
// - Stage i, lines (u,d): u_out = chal_i ? d_in : u_in  (#DLY_UP); d_out = chal_i ? u_in : d_in  (#DLY_DN).
// - Both line inputs of every chain are driven by the common launch net.
// - Arbiter flop per chain: D=u line, clock = rising edge of d line, async clear = arb_clr. It outputs 1 iff u wins the race.
// - Handshake: chal is latched when chal_valid && chal_ready (IDLE only). Later chal changes are ignored until IDLE.
// - FSM:
//   - IDLE->ARM on accept.
//   - ARM (1 cyc): arb_clr=1, launch=0.
//   - LAUNCH (1 cyc): launch=1.
//   - SETTLE (SETTLE_CYC cyc).
//   - SAMPLE (1 cyc): sync the arbiter outputs through 2 flops, then count ones per chain.
//   - SAMPLE->RELAX if more votes are pending, else DONE.
//   - RELAX (SETTLE_CYC cyc): launch=0, then ARM.
//   - DONE: resp_valid=1; DONE->IDLE on resp_ready.
// - Latency, from the accept edge to resp_valid rising:
//   - 4+SETTLE_CYC cycles for a single evaluation.
//   - Each extra vote adds 2*SETTLE_CYC+3.
// - Back-to-back: chal_ready rises the cycle after the resp handshake, so there is at least one idle cycle between challenges.
// - Backpressure: resp and resp_xor hold stable while resp_valid && !resp_ready. No timeout.
// - Votes:
//   - Per-chain counter width is $clog2(VOTES+1).
//   - resp[c] = cnt[c] > VOTES/2. Counters clear on ARM of the first vote.
// - Simultaneous chal_valid with resp handshake in DONE: the challenge is not accepted (chal_ready=0) until IDLE.
// CONFIGURATION
// - `PUF_VOTE_EN defined: VOTES evaluations per challenge, with per-chain majority.
// - `PUF_VOTE_EN undefined: exactly one evaluation. VOTES is ignored, no counters; resp[c] = the sampled bit.
// TESTING
// - Reset: assert reset mid-SETTLE -> next cycle resp_valid=0, chal_ready=1, busy=0, resp=0.
// - Single eval, N_STAGES=8, N_CHAINS=4, SETTLE_CYC=4, chal=8'h00 -> resp=4'hF, resp_xor=0, resp_valid 8 cycles after accept.
// - Swapped delays, DLY_UP=0.2, DLY_DN=0.1, chal=8'h00 -> resp=4'h0, resp_xor=0.
// - Backpressure: resp_ready=0 for 10 cycles -> resp stable, chal_ready=0. Raise resp_ready -> chal_ready=1 the next cycle.
// - PUF_VOTE_EN, VOTES=3, SETTLE_CYC=4 -> resp_valid 8+2*11=30 cycles after accept; resp equals the single-eval result.
// - Challenge change while busy: alter chal after accept -> resp matches the latched challenge; second accept only after DONE.

Source files
------------

// File: rtl/arbiter_puf_array.sv
// Multi-chain arbiter PUF with challenge/response evaluation controller.
// Define PUF_VOTE_EN for VOTES-fold evaluation with per-chain majority; otherwise a single evaluation.
module arbiter_puf_array #(
   parameter int unsigned N_STAGES   = 64,
   parameter int unsigned N_CHAINS   = 4,
   parameter int unsigned SETTLE_CYC = 8,
   parameter int unsigned VOTES      = 5,
   parameter real         DLY_UP     = 0.1,
   parameter real         DLY_DN     = 0.2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                chal_valid,
   output logic                chal_ready,
   input  logic [N_STAGES-1:0] chal,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [N_CHAINS-1:0] resp,
   output logic                resp_xor,
   output logic                busy
);

   // Stage delays as integer picosecond weights, fixed at elaboration.
   localparam int unsigned W_UP = $rtoi(DLY_UP * 1000.0 + 0.5);
   localparam int unsigned W_DN = $rtoi(DLY_DN * 1000.0 + 0.5);
   localparam int unsigned TW   = $clog2(SETTLE_CYC + 1);

   typedef enum logic [2:0] {IDLE, ARM, LAUNCH, SETTLE, SAMPLE, RELAX, DONE} state_t;

   state_t              state_q, state_d;
   logic [N_STAGES-1:0] chal_q, chal_d;
   logic [TW-1:0]       tmr_q, tmr_d;
   logic                launch_q, launch_d;
   logic [N_CHAINS-1:0] arb_q, arb_d;
   logic [N_CHAINS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic [N_CHAINS-1:0] resp_q, resp_d;
   logic                resp_xor_q, resp_xor_d;
   logic                resp_valid_q, resp_valid_d;
   logic                chal_ready_q, chal_ready_d;
   logic                busy_q, busy_d;
   logic [N_CHAINS-1:0] race;
   logic [N_STAGES-1:0] cc;
`ifdef PUF_VOTE_EN
   localparam int unsigned CW = $clog2(VOTES + 1);
   logic [N_CHAINS-1:0][CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0]               vote_q, vote_d;
`else
   logic [N_CHAINS-1:0] samp_q, samp_d;
`endif

   // Race through the switch boxes: returns 1 when the upper line reaches the arbiter first.
   function automatic logic race_win(input logic [N_STAGES-1:0] sel);
      logic [31:0] tu, td, nu;
      tu = '0;
      td = '0;
      for (int unsigned i = 0; i < N_STAGES; i++) begin
         nu = (sel[i] ? td : tu) + W_UP;
         td = (sel[i] ? tu : td) + W_DN;
         tu = nu;
      end
      return tu < td;
   endfunction

   always_comb begin
      race = '0;
      for (int unsigned c = 0; c < N_CHAINS; c++) begin
         cc = '0;
         for (int unsigned i = 0; i < N_STAGES; i++)
            cc[i] = chal_q[(i + N_STAGES - (c % N_STAGES)) % N_STAGES];
         race[c] = race_win(cc);
      end
   end

   always_comb begin
      state_d      = state_q;
      chal_d       = chal_q;
      tmr_d        = tmr_q;
      resp_d       = resp_q;
      resp_xor_d   = resp_xor_q;
      resp_valid_d = resp_valid_q;
`ifdef PUF_VOTE_EN
      cnt_d        = cnt_q;
      vote_d       = vote_q;
`else
      samp_d       = samp_q;
`endif
      case (state_q)
         IDLE: if (chal_valid && chal_ready_q) begin
            chal_d  = chal;
            state_d = ARM;
`ifdef PUF_VOTE_EN
            vote_d  = '0;
`endif
         end
         ARM: begin
            state_d = LAUNCH;
`ifdef PUF_VOTE_EN
            if (vote_q == '0) cnt_d = '0;
`endif
         end
         LAUNCH: begin
            state_d = SETTLE;
            tmr_d   = '0;
         end
         SETTLE: begin
            tmr_d = tmr_q + 1'b1;
            if (tmr_q == TW'(SETTLE_CYC - 1)) state_d = SAMPLE;
         end
         SAMPLE: begin
`ifdef PUF_VOTE_EN
            for (int unsigned c = 0; c < N_CHAINS; c++)
               cnt_d[c] = cnt_q[c] + CW'(sync2_q[c]);
            vote_d = vote_q + 1'b1;
            if (vote_q == CW'(VOTES - 1)) begin
               state_d = DONE;
            end else begin
               state_d = RELAX;
               tmr_d   = '0;
            end
`else
            samp_d  = sync2_q;
            state_d = DONE;
`endif
         end
         RELAX: begin
            tmr_d = tmr_q + 1'b1;
            if (tmr_q == TW'(SETTLE_CYC - 1)) state_d = ARM;
         end
         DONE: begin
            // First DONE cycle registers the result; valid rises with it so no partial value is seen.
            if (!resp_valid_q) begin
`ifdef PUF_VOTE_EN
               for (int unsigned c = 0; c < N_CHAINS; c++)
                  resp_d[c] = (cnt_q[c] > CW'(VOTES / 2));
`else
               resp_d = samp_q;
`endif
               resp_xor_d   = ^resp_d;
               resp_valid_d = 1'b1;
            end else if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      launch_d     = (state_d == LAUNCH) || (state_d == SETTLE) || (state_d == SAMPLE);
      chal_ready_d = (state_d == IDLE);
      busy_d       = (state_d != IDLE);

      // Arbiters capture on the launch edge and are cleared while arming.
      arb_d = arb_q;
      if (launch_d && !launch_q) arb_d = race;
      else if (state_d == ARM)   arb_d = '0;
      sync1_d = arb_q;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         chal_q       <= '0;
         tmr_q        <= '0;
         launch_q     <= 1'b0;
         arb_q        <= '0;
         sync1_q      <= '0;
         sync2_q      <= '0;
         resp_q       <= '0;
         resp_xor_q   <= 1'b0;
         resp_valid_q <= 1'b0;
         chal_ready_q <= 1'b1;
         busy_q       <= 1'b0;
`ifdef PUF_VOTE_EN
         cnt_q        <= '0;
         vote_q       <= '0;
`else
         samp_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         chal_q       <= chal_d;
         tmr_q        <= tmr_d;
         launch_q     <= launch_d;
         arb_q        <= arb_d;
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         resp_q       <= resp_d;
         resp_xor_q   <= resp_xor_d;
         resp_valid_q <= resp_valid_d;
         chal_ready_q <= chal_ready_d;
         busy_q       <= busy_d;
`ifdef PUF_VOTE_EN
         cnt_q        <= cnt_d;
         vote_q       <= vote_d;
`else
         samp_q       <= samp_d;
`endif
      end
   end

   assign chal_ready = chal_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp       = resp_q;
   assign resp_xor   = resp_xor_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_arbiter_puf_array.sv
// Directed bench for arbiter_puf_array: two instances with normal and swapped stage delays.
module tb_arbiter_puf_array;
   localparam int unsigned NS = 8;
   localparam int unsigned NC = 4;
   localparam int unsigned SC = 4;
   localparam int unsigned NV = 3;
`ifdef PUF_VOTE_EN
   localparam int EXP_LAT = 4 + SC + (NV - 1) * (2 * SC + 3);
`else
   localparam int EXP_LAT = 4 + SC;
`endif

   logic          clk, reset, chal_valid, resp_ready;
   logic [NS-1:0] chal;
   logic          a_chal_ready, a_resp_valid, a_resp_xor, a_busy;
   logic [NC-1:0] a_resp;
   logic          b_chal_ready, b_resp_valid, b_resp_xor, b_busy;
   logic [NC-1:0] b_resp;
   int            n_cmp = 0;
   int            n_bad = 0;
   int            lat;

   arbiter_puf_array #(.N_STAGES(NS), .N_CHAINS(NC), .SETTLE_CYC(SC), .VOTES(NV),
                       .DLY_UP(0.1), .DLY_DN(0.2)) dut_a (
      .clk(clk), .reset(reset), .chal_valid(chal_valid), .chal_ready(a_chal_ready),
      .chal(chal), .resp_valid(a_resp_valid), .resp_ready(resp_ready),
      .resp(a_resp), .resp_xor(a_resp_xor), .busy(a_busy));

   arbiter_puf_array #(.N_STAGES(NS), .N_CHAINS(NC), .SETTLE_CYC(SC), .VOTES(NV),
                       .DLY_UP(0.2), .DLY_DN(0.1)) dut_b (
      .clk(clk), .reset(reset), .chal_valid(chal_valid), .chal_ready(b_chal_ready),
      .chal(chal), .resp_valid(b_resp_valid), .resp_ready(resp_ready),
      .resp(b_resp), .resp_xor(b_resp_xor), .busy(b_busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic offer(input logic [NS-1:0] c, input bit keep);
      @(negedge clk);
      check("ready_before_offer", 32'(a_chal_ready), 32'd1);
      chal       = c;
      chal_valid = 1'b1;
      @(posedge clk);
      if (!keep) begin
         #1;
         chal_valid = 1'b0;
      end
   endtask

   task automatic wait_valid(input string tag, output int l);
      l = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         l++;
         if (a_resp_valid) break;
      end
      check({tag, "_valid"}, 32'(a_resp_valid), 32'd1);
      check({tag, "_b_valid"}, 32'(b_resp_valid), 32'd1);
   endtask

   task automatic handshake(input string tag);
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      check({tag, "_ready_after_hs"}, 32'(a_chal_ready), 32'd1);
      check({tag, "_valid_after_hs"}, 32'(a_resp_valid), 32'd0);
   endtask

   initial begin
      reset      = 1'b1;
      chal_valid = 1'b0;
      chal       = '0;
      resp_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_resp", 32'(a_resp), 32'd0);
      check("rst_xor", 32'(a_resp_xor), 32'd0);
      check("rst_valid", 32'(a_resp_valid), 32'd0);
      check("rst_ready", 32'(a_chal_ready), 32'd1);
      check("rst_busy", 32'(a_busy), 32'd0);
      reset = 1'b0;

      // All-straight challenge: upper line is faster in A, slower in B.
      offer(8'h00, 1'b0);
      wait_valid("c00", lat);
      check("c00_lat", 32'(lat), 32'(EXP_LAT));
      check("c00_resp", 32'(a_resp), 32'hF);
      check("c00_xor", 32'(a_resp_xor), 32'd0);
      check("c00_b_resp", 32'(b_resp), 32'h0);
      check("c00_b_xor", 32'(b_resp_xor), 32'd0);
      check("c00_busy", 32'(a_busy), 32'd1);
      handshake("c00");
      check("c00_idle", 32'(a_busy), 32'd0);

      // Single crossing in stage 7 (chain 0); rotated chains see it at stages 0,1,2.
      offer(8'h80, 1'b0);
      wait_valid("c80", lat);
      check("c80_lat", 32'(lat), 32'(EXP_LAT));
      check("c80_b_resp", 32'(b_resp), 32'h1);
      check("c80_b_xor", 32'(b_resp_xor), 32'd1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("bp_resp", 32'(a_resp), 32'hE);
         check("bp_xor", 32'(a_resp_xor), 32'd1);
         check("bp_valid", 32'(a_resp_valid), 32'd1);
         check("bp_ready", 32'(a_chal_ready), 32'd0);
      end
      handshake("bp");

      // Challenge altered after accept and held valid through DONE.
      offer(8'h80, 1'b1);
      @(negedge clk);
      chal = 8'h00;
      check("chg_ready_busy", 32'(a_chal_ready), 32'd0);
      wait_valid("chg", lat);
      check("chg_resp", 32'(a_resp), 32'hE);
      check("chg_ready_done", 32'(a_chal_ready), 32'd0);
      handshake("chg");
      check("chg_not_accepted", 32'(a_busy), 32'd0);
      @(posedge clk);
      #1;
      chal_valid = 1'b0;
      check("chg2_busy", 32'(a_busy), 32'd1);
      wait_valid("chg2", lat);
      check("chg2_lat", 32'(lat), 32'(EXP_LAT));
      check("chg2_resp", 32'(a_resp), 32'hF);
      handshake("chg2");

      // Reset during SETTLE aborts the evaluation immediately.
      offer(8'h80, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("mid_busy", 32'(a_busy), 32'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_valid", 32'(a_resp_valid), 32'd0);
      check("mid_rst_ready", 32'(a_chal_ready), 32'd1);
      check("mid_rst_busy", 32'(a_busy), 32'd0);
      check("mid_rst_resp", 32'(a_resp), 32'd0);
      check("mid_rst_xor", 32'(a_resp_xor), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      offer(8'h80, 1'b0);
      wait_valid("rec", lat);
      check("rec_lat", 32'(lat), 32'(EXP_LAT));
      check("rec_resp", 32'(a_resp), 32'hE);
      check("rec_b_resp", 32'(b_resp), 32'h1);
      handshake("rec");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
